serial_sign_addsub: RTL and testbench
=====================================

Name: serial_sign_addsub

Overview:
- Parametrised, multi-cycle, digit-serial signed adder/subtractor. It is the sequential successor to the team's fixed 8-bit ripple add/sub.
- Processes DIGIT bits per clock over WIDTH/DIGIT cycles, using a start/busy/done handshake.
- Reports sum, carry-out, two's-complement overflow and zero.
- Sits beside the datapath ALU for wide operands where a full-width ripple path would break timing.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of DIGIT, at least 2.
- DIGIT, 4, bits processed per cycle; 1 ≤ DIGIT ≤ WIDTH. NDIG = WIDTH/DIGIT.

Ports:
- clk  input  1  single clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- start  input  1  request; sampled only when busy=0.
- sub  input  1  0 = a+b, 1 = a-b; latched with operands.
- a  input  WIDTH  operand A, two's complement; latched on accepted start.
- b  input  WIDTH  operand B, two's complement; latched on accepted start.
- busy  output  1  high while in RUN.
- done  output  1  one-cycle pulse; results valid from this cycle on.
- s  output  WIDTH  result.
- cout  output  1  carry out of MSB; for sub, 1 = no borrow.
- v  output  1  signed overflow, equal to carry into MSB xor carry out of MSB.
- zero  output  1  s == 0.

Behaviour:
- Reset (asynchronous, rst_n low, any state): state=IDLE, digit counter=0, busy=0, done=0, s=0, cout=0, v=0, zero=1. Any in-flight operation is discarded without a done pulse.
- FSM states:
  - IDLE: start=1 at a rising edge latches a, b and sub. Internal carry is set to sub; operand B is used inverted when sub=1. Counter=0, go to RUN, busy=1.
  - RUN: each edge adds digit[counter] of A, B' and the carry. The DIGIT-bit sum is written into the internal result register; carry is updated and counter increments.
  - On the edge that processes digit NDIG-1: capture the carry into the MSB and the final carry. Update s, cout, v and zero together. Set done=1, busy=0, return to IDLE.
- Latency: start accepted at edge 0 → done high and results updated at edge NDIG (4 cycles at the defaults).
- Throughput: one operation per NDIG cycles. start is accepted in the same cycle done is high (back-to-back).
- done: exactly one cycle wide. Outputs s, cout, v and zero hold their last values until the next done. They do not change mid-operation.
- start while busy=1: ignored, no effect on operands or timing. sub, a and b may change freely after acceptance.
- DIGIT = WIDTH: single RUN cycle, latency 1.
- v is derived from the carry into bit WIDTH-1 captured in the final digit. When DIGIT=1 that is the carry entering the last cycle.
- Arithmetic is modulo 2^WIDTH; no sign extension of the result.

Optional Feature:
- Macro: SERIAL_ADDSUB_SATURATE_EN.
- Defined: when v=1, s is clamped. If the latched a[WIDTH-1]=0, s = max positive (0x7FFF at defaults); otherwise s = min negative (0x8000). v and cout still report the raw overflow and carry; zero reflects the clamped s.
- Not defined: s is the raw wrapped result. The saturation mux is not built.

Test Plan (WIDTH=16, DIGIT=4):
- a=0x7FFF, b=0x0001, sub=0 → after 4 cycles: done pulse, s=0x8000, v=1, cout=0, zero=0. With SATURATE_EN: s=0x7FFF, v=1.
- a=0x0005, b=0x0007, sub=1 → s=0xFFFE, cout=0, v=0. Then back-to-back start in the done cycle with a=0x8000, b=0x0001, sub=1 → 4 cycles later s=0x7FFF, v=1, cout=1 (SATURATE_EN: s=0x8000).
- a=0xFFFF, b=0x0001, sub=0 → s=0x0000, cout=1, v=0, zero=1; busy high for exactly 4 cycles.
- Accept a=0x1234+b=0x1111. Pulse start with a=0xFFFF at cycle 2 of RUN, and change a/b while busy → ignored; done at cycle 4 with s=0x2345; no second done.
- Start 0x1234+0x1111, assert rst_n=0 at cycle 2 → busy=0, s=0, zero=1 immediately; no done pulse. After release, a new start of 0x0001+0x0001 gives s=0x0002.
- Parameter sweep DIGIT=1, 16 (WIDTH=16) with 0x7FFF+0x0001 → latency 16 and 1 respectively; s=0x8000, v=1 in both.

Source files
------------

// File: rtl/serial_sign_addsub.sv
// rtl/serial_sign_addsub.sv - digit-serial signed adder/subtractor with start/busy/done handshake
//
// Adds or subtracts two WIDTH-bit two's-complement operands DIGIT bits per
// clock, finishing NDIG = WIDTH/DIGIT cycles after an accepted start.
//
// Optional build macro: SERIAL_ADDSUB_SATURATE_EN
//   defined   -> s is clamped to max positive / min negative on signed overflow
//   undefined -> s is the raw result, modulo 2^WIDTH
//
// Ports:
//   clk    in   clock, all state on the rising edge
//   rst_n  in   asynchronous active-low reset
//   start  in   request, sampled only while idle
//   sub    in   0 = a+b, 1 = a-b (latched with the operands)
//   a, b   in   WIDTH-bit two's-complement operands (latched on accepted start)
//   busy   out  high while an operation is running
//   done   out  one-cycle pulse, results valid from this cycle on
//   s      out  WIDTH-bit result
//   cout   out  carry out of the MSB (for sub, 1 = no borrow)
//   v      out  signed overflow
//   zero   out  s == 0
module serial_sign_addsub #(
  parameter int WIDTH = 16,
  parameter int DIGIT = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             sub,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] s,
  output logic             cout,
  output logic             v,
  output logic             zero
);

  localparam int NDIG = WIDTH / DIGIT;
  localparam int CW   = (NDIG > 1) ? $clog2(NDIG) : 1;
  localparam logic [CW-1:0] LAST = CW'(NDIG - 1);

  typedef enum logic {
    IDLE = 1'b0,
    RUN  = 1'b1
  } state_t;

  state_t state_q, state_d;

  // Latched operands; b_q already holds ~b for subtraction.
  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] b_q, b_d;
  logic [WIDTH-1:0] res_q, res_d;
  logic             carry_q, carry_d;
  logic [CW-1:0]    cnt_q, cnt_d;

  // Visible result registers, only written on the final digit.
  logic [WIDTH-1:0] s_q, s_d;
  logic             cout_q, cout_d;
  logic             v_q, v_d;
  logic             zero_q, zero_d;
  logic             done_q, done_d;

  logic             accept;
  logic             last_digit;
  int               dig_base;
  logic [DIGIT-1:0] a_dig;
  logic [DIGIT-1:0] b_dig;
  logic [DIGIT:0]   dig_add;
  logic [DIGIT-1:0] sum_dig;
  logic             dig_cout;
  logic             msb_cin;
  logic             ovf;
  logic [WIDTH-1:0] s_raw;
  logic [WIDTH-1:0] s_fin;

  assign accept     = (state_q == IDLE) && start;
  assign last_digit = (state_q == RUN) && (cnt_q == LAST);
  assign dig_base   = int'(cnt_q) * DIGIT;

  // ---------------------------------------------------------------------------
  // Digit adder
  // ---------------------------------------------------------------------------
  always_comb begin
    a_dig    = a_q[dig_base +: DIGIT];
    b_dig    = b_q[dig_base +: DIGIT];
    dig_add  = {1'b0, a_dig} + {1'b0, b_dig} + {{DIGIT{1'b0}}, carry_q};
    sum_dig  = dig_add[DIGIT-1:0];
    dig_cout = dig_add[DIGIT];
    // The carry into the top bit of this digit falls out of the sum identity
    // s = a ^ b ^ cin; this also holds for DIGIT = 1, where it is carry_q.
    msb_cin  = a_dig[DIGIT-1] ^ b_dig[DIGIT-1] ^ sum_dig[DIGIT-1];
    ovf      = msb_cin ^ dig_cout;
  end

  // Result word with the current digit merged in; on the last digit this is
  // the complete sum.
  always_comb begin
    s_raw                     = res_q;
    s_raw[dig_base +: DIGIT]  = sum_dig;
  end

`ifdef SERIAL_ADDSUB_SATURATE_EN
  // On overflow the true result has the sign of a, so clamp toward it.
  always_comb begin
    s_fin = s_raw;
    if (ovf) begin
      if (a_q[WIDTH-1]) begin
        s_fin = {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        s_fin = {1'b0, {(WIDTH-1){1'b1}}};
      end
    end
  end
`else
  assign s_fin = s_raw;
`endif

  // ---------------------------------------------------------------------------
  // FSM: state register
  // ---------------------------------------------------------------------------
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // FSM: next state
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE: if (start)      state_d = RUN;
      RUN:  if (last_digit) state_d = IDLE;
      default:              state_d = IDLE;
    endcase
  end

  // FSM: outputs
  always_comb begin
    busy = (state_q == RUN);
  end

  // ---------------------------------------------------------------------------
  // Datapath next state
  // ---------------------------------------------------------------------------
  always_comb begin
    a_d     = a_q;
    b_d     = b_q;
    res_d   = res_q;
    carry_d = carry_q;
    cnt_d   = cnt_q;
    s_d     = s_q;
    cout_d  = cout_q;
    v_d     = v_q;
    zero_d  = zero_q;
    done_d  = 1'b0;

    if (accept) begin
      a_d     = a;
      b_d     = sub ? ~b : b;
      carry_d = sub;           // +1 of the two's-complement negation
      cnt_d   = '0;
    end else if (state_q == RUN) begin
      res_d   = s_raw;
      carry_d = dig_cout;
      if (last_digit) begin
        cnt_d  = '0;
        done_d = 1'b1;
        s_d    = s_fin;
        cout_d = dig_cout;
        v_d    = ovf;
        zero_d = (s_fin == '0);
      end else begin
        cnt_d  = cnt_q + 1'b1;
      end
    end
  end

  // Datapath registers
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      a_q     <= '0;
      b_q     <= '0;
      res_q   <= '0;
      carry_q <= 1'b0;
      cnt_q   <= '0;
      s_q     <= '0;
      cout_q  <= 1'b0;
      v_q     <= 1'b0;
      zero_q  <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      a_q     <= a_d;
      b_q     <= b_d;
      res_q   <= res_d;
      carry_q <= carry_d;
      cnt_q   <= cnt_d;
      s_q     <= s_d;
      cout_q  <= cout_d;
      v_q     <= v_d;
      zero_q  <= zero_d;
      done_q  <= done_d;
    end
  end

  assign done = done_q;
  assign s    = s_q;
  assign cout = cout_q;
  assign v    = v_q;
  assign zero = zero_q;

endmodule

// File: tb/tb_serial_sign_addsub.sv
// tb/tb_serial_sign_addsub.sv - self-checking bench for serial_sign_addsub
module tb_serial_sign_addsub;

  localparam int W = 16;
`ifdef SERIAL_ADDSUB_SATURATE_EN
  localparam bit SAT = 1'b1;
`else
  localparam bit SAT = 1'b0;
`endif

  logic         clk = 1'b0;
  logic         rst_n = 1'b0;
  logic         start = 1'b0;
  logic         sub = 1'b0;
  logic [W-1:0] a = '0;
  logic [W-1:0] b = '0;

  logic         busy4, done4, cout4, v4, zero4;
  logic [W-1:0] s4;
  logic         busy1, done1, cout1, v1, zero1;
  logic [W-1:0] s1;
  logic         busy16, done16, cout16, v16, zero16;
  logic [W-1:0] s16;

  always #5 clk = ~clk;

  serial_sign_addsub #(.WIDTH(W), .DIGIT(4)) dut4 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy4), .done(done4), .s(s4), .cout(cout4), .v(v4), .zero(zero4)
  );

  serial_sign_addsub #(.WIDTH(W), .DIGIT(1)) dut1 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy1), .done(done1), .s(s1), .cout(cout1), .v(v1), .zero(zero1)
  );

  serial_sign_addsub #(.WIDTH(W), .DIGIT(16)) dut16 (
    .clk(clk), .rst_n(rst_n), .start(start), .sub(sub), .a(a), .b(b),
    .busy(busy16), .done(done16), .s(s16), .cout(cout16), .v(v16), .zero(zero16)
  );

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference arithmetic on plain integers.
  typedef struct packed {
    logic [W-1:0] s;
    logic         cout;
    logic         v;
    logic         zero;
  } res_t;

  function automatic res_t calc(input logic [W-1:0] x, input logic [W-1:0] y, input logic op);
    res_t r;
    int   sx, sy, t;
    sx = int'($signed(x));
    sy = int'($signed(y));
    t  = op ? (sx - sy) : (sx + sy);
    r.v    = (t > 32767) || (t < -32768);
    r.cout = op ? (x >= y) : ((int'(x) + int'(y)) > 65535);
    r.s    = t[W-1:0];
    if (SAT && r.v) r.s = (t > 0) ? 16'h7FFF : 16'h8000;
    r.zero = (r.s == '0);
    return r;
  endfunction

  // Transaction-level model of the DIGIT=4 instance.
  localparam int NDIG4 = 4;
  localparam res_t RST_RES = {16'h0000, 1'b0, 1'b0, 1'b1};
  logic m_pend = 1'b0;
  logic m_done = 1'b0;
  int   m_left = 0;
  res_t m_res  = RST_RES;
  res_t m_next = RST_RES;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_pend <= 1'b0;
      m_done <= 1'b0;
      m_left <= 0;
      m_res  <= RST_RES;
    end else begin
      m_done <= 1'b0;
      if (m_pend) begin
        if (m_left == 1) begin
          m_pend <= 1'b0;
          m_done <= 1'b1;
          m_res  <= m_next;
        end
        m_left <= m_left - 1;
      end else if (start) begin
        m_pend <= 1'b1;
        m_left <= NDIG4;
        m_next <= calc(a, b, sub);
      end
    end
  end

  always begin
    @(negedge clk);
    #1;
    chk("cyc_busy", busy4, m_pend);
    chk("cyc_done", done4, m_done);
    chk("cyc_s",    s4,    m_res.s);
    chk("cyc_cout", cout4, m_res.cout);
    chk("cyc_v",    v4,    m_res.v);
    chk("cyc_zero", zero4, m_res.zero);
  end

  // Called at a falling edge; returns at the falling edge where done is seen.
  task automatic run_op(input string name, input logic [W-1:0] x, input logic [W-1:0] y,
                        input logic op, input logic [W-1:0] es, input logic ec,
                        input logic ev, input logic ez);
    int lat, bcnt;
    start = 1'b1; a = x; b = y; sub = op;
    @(negedge clk);
    start = 1'b0; a = 16'($urandom); b = 16'($urandom); sub = 1'($urandom);
    lat = 0; bcnt = 0;
    while (!done4 && lat < 40) begin
      if (busy4) bcnt++;
      @(negedge clk);
      lat++;
    end
    chk({name, "_lat"},  lat,   4);
    chk({name, "_busy"}, bcnt,  4);
    chk({name, "_s"},    s4,    es);
    chk({name, "_cout"}, cout4, ec);
    chk({name, "_v"},    v4,    ev);
    chk({name, "_zero"}, zero4, ez);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    int lat, dn, l4, l1, l16;

    rst_n = 1'b0;
    repeat (2) @(negedge clk);
    chk("rst_busy", busy4, 0);
    chk("rst_done", done4, 0);
    chk("rst_s",    s4,    0);
    chk("rst_cout", cout4, 0);
    chk("rst_v",    v4,    0);
    chk("rst_zero", zero4, 1);
    rst_n = 1'b1;
    @(negedge clk);

    run_op("ovf_add", 16'h7FFF, 16'h0001, 1'b0, SAT ? 16'h7FFF : 16'h8000, 1'b0, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    run_op("sub_neg", 16'h0005, 16'h0007, 1'b1, 16'hFFFE, 1'b0, 1'b0, 1'b0);
    // Back-to-back: start issued in the done cycle.
    run_op("b2b_sub", 16'h8000, 16'h0001, 1'b1, SAT ? 16'h8000 : 16'h7FFF, 1'b1, 1'b1, 1'b0);
    repeat (2) @(negedge clk);

    run_op("wrap", 16'hFFFF, 16'h0001, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1);
    repeat (2) @(negedge clk);

    // Start and operand changes while busy are ignored.
    start = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    start = 1'b1; a = 16'hFFFF; b = 16'h7777; sub = 1'b1;
    @(negedge clk);
    start = 1'b0; a = 16'h0000; b = 16'h0000; sub = 1'b0;
    lat = 2;
    while (!done4 && lat < 40) begin
      @(negedge clk);
      lat++;
    end
    chk("ign_lat", lat, 4);
    chk("ign_s",   s4,  16'h2345);
    dn = 0;
    repeat (10) begin
      @(negedge clk);
      if (done4) dn++;
    end
    chk("ign_no_second_done", dn, 0);

    // Reset in the middle of an operation.
    start = 1'b1; a = 16'h1234; b = 16'h1111; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("mrst_busy", busy4, 0);
    chk("mrst_s",    s4,    0);
    chk("mrst_zero", zero4, 1);
    chk("mrst_done", done4, 0);
    dn = 0;
    repeat (4) begin
      @(negedge clk);
      if (done4) dn++;
    end
    chk("mrst_no_done", dn, 0);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("after_rst", 16'h0001, 16'h0001, 1'b0, 16'h0002, 1'b0, 1'b0, 1'b0);

    // DIGIT sweep: let the DIGIT=1 instance drain, then start all three together.
    repeat (20) @(negedge clk);
    start = 1'b1; a = 16'h7FFF; b = 16'h0001; sub = 1'b0;
    @(negedge clk);
    start = 1'b0;
    l4 = -1; l1 = -1; l16 = -1;
    for (int k = 0; k < 40; k++) begin
      if (done4  && l4  < 0) l4  = k;
      if (done1  && l1  < 0) l1  = k;
      if (done16 && l16 < 0) l16 = k;
      @(negedge clk);
    end
    chk("sw4_lat",   l4,  4);
    chk("sw1_lat",   l1,  16);
    chk("sw16_lat",  l16, 1);
    chk("sw1_s",     s1,  SAT ? 16'h7FFF : 16'h8000);
    chk("sw1_v",     v1,  1);
    chk("sw1_cout",  cout1, 0);
    chk("sw1_zero",  zero1, 0);
    chk("sw1_busy",  busy1, 0);
    chk("sw16_s",    s16, SAT ? 16'h7FFF : 16'h8000);
    chk("sw16_v",    v16, 1);
    chk("sw16_cout", cout16, 0);
    chk("sw16_zero", zero16, 0);
    chk("sw16_busy", busy16, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
